// File: rtl/merge_arb.sv
// Round-robin merge of N_MASTERS simple request/ready buses onto one slave bus.
// A grant is locked from selection until the slave returns ready.
module merge_arb #(
    parameter int N_MASTERS = 2,
    parameter int ADDR_W    = 32
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic [N_MASTERS*(ADDR_W+37)-1:0]    m_req,
    output logic [N_MASTERS*33-1:0]             m_resp,
    output logic [ADDR_W+36:0]                  s_req,
    input  logic [32:0]                         s_resp
);

    // Request slice: {valid, addr, wdata[31:0], wstrb[3:0]}; response slice: {rdata[31:0], ready}.
    localparam int REQ_W  = ADDR_W + 37;
    localparam int RESP_W = 33;
    localparam int IDX_W  = $clog2(N_MASTERS);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    state_e             state_q;
    logic [IDX_W-1:0]   grant_q;
    logic [IDX_W-1:0]   rr_ptr_q;

    logic [N_MASTERS-1:0] m_valid;
    logic                 any_valid;
    logic [IDX_W-1:0]     grant_d;
    logic [IDX_W-1:0]     rr_ptr_d;
    logic                 s_ready;

    assign s_ready = s_resp[0];

    always_comb begin
        for (int i = 0; i < N_MASTERS; i++) begin
            m_valid[i] = m_req[i*REQ_W + REQ_W - 1];
        end
    end

    // Lowest requester at or above rr_ptr wins; otherwise wrap to the lowest requester overall.
    always_comb begin
        logic             hi_found;
        logic [IDX_W-1:0] hi_idx;
        logic [IDX_W-1:0] lo_idx;
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        hi_found  = 1'b0;
        hi_idx    = '0;
        lo_idx    = '0;
        any_valid = |m_valid;
        for (int i = N_MASTERS - 1; i >= 0; i--) begin
            if (m_valid[i]) begin
                lo_idx = IDX_W'(i);
                if (i >= int'(rr_ptr_q)) begin
                    hi_found = 1'b1;
                    hi_idx   = IDX_W'(i);
                end
            end
        end
        grant_d = hi_found ? hi_idx : lo_idx;
    end

    // Explicit wrap keeps the pointer below N_MASTERS for non-power-of-2 counts.
    always_comb begin
        if (grant_q == IDX_W'(N_MASTERS - 1)) begin
            rr_ptr_d = '0;
        end else begin
            rr_ptr_d = grant_q + IDX_W'(1);
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            grant_q  <= '0;
            rr_ptr_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_valid) begin
                        grant_q <= grant_d;
                        state_q <= BUSY;
                    end
                end
                BUSY: begin
                    if (s_ready) begin
                        rr_ptr_q <= rr_ptr_d;
                        state_q  <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Data path is a pure mux on the locked grant; reset forces IDLE, which zeroes both sides at once.
    always_comb begin
        s_req  = '0;
        m_resp = '0;
        for (int i = 0; i < N_MASTERS; i++) begin
            if (state_q == BUSY && grant_q == IDX_W'(i)) begin
                s_req                      = m_req[i*REQ_W +: REQ_W];
                m_resp[i*RESP_W +: RESP_W] = s_resp;
            end
        end
    end

endmodule

// File: doc/merge_arb.md
MERGE_ARB -- requirements
Module: merge_arb

Interface
REQ-001 The parameter N_MASTERS SHALL default to 2 and set the number of master ports, with a legal range of 2 to 16.
REQ-002 The parameter ADDR_W SHALL default to 32 and set the address width carried on every master bus and on the slave bus.
REQ-003 The port clk SHALL be an input of width 1 and is the single system clock; all state updates on the rising edge.
REQ-004 The port rst_n SHALL be an input of width 1 and is the asynchronous, active-low reset.
REQ-005 The port m_req SHALL be an input of width N_MASTERS*BUS_REQ_W(ADDR_W) carrying the concatenated master requests, with master i at slice i; each slice is {valid, addr[ADDR_W-1:0], wdata[31:0], wstrb[3:0]} MSB to LSB.
REQ-006 The port m_resp SHALL be an output of width N_MASTERS*BUS_RESP_W carrying the concatenated master responses; each slice is {rdata[31:0], ready} MSB to LSB.
REQ-007 The port s_req SHALL be an output of width BUS_REQ_W(ADDR_W) carrying the single slave request, in the same field layout as a master request.
REQ-008 The port s_resp SHALL be an input of width BUS_RESP_W carrying the single slave response.

Function
REQ-009 The block SHALL arbitrate N_MASTERS bus masters onto one slave; it is the converging counterpart of the one-to-many address split.
REQ-010 The state machine SHALL have exactly two states: IDLE and BUSY.
REQ-011 In IDLE, when any master valid=1, the block SHALL select the requesting master nearest at or after rr_ptr (round-robin, wrapping N_MASTERS-1 to 0), register its index in grant, and move to BUSY on the next edge.
REQ-012 In IDLE with no master valid=1, the block SHALL stay in IDLE and leave grant and rr_ptr unchanged.
REQ-013 In IDLE, s_req SHALL be all zeros.
REQ-014 In IDLE, every master's ready SHALL be 0.
REQ-015 In BUSY, s_req SHALL equal m_req slice grant, passed through combinationally and unmodified.
REQ-016 In BUSY, m_resp slice grant SHALL equal s_resp combinationally.
REQ-017 In BUSY, every other master slice SHALL be rdata=0 and ready=0.
REQ-018 In BUSY with s_resp.ready=1, the block SHALL return to IDLE and set rr_ptr = (grant+1) mod N_MASTERS on the same edge.
REQ-019 In BUSY with s_resp.ready=0, the block SHALL hold state and grant, so the grant is locked for the whole transaction.
REQ-020 Latency: a request arriving while the block is IDLE SHALL reach s_req one cycle later.
REQ-021 Back-to-back transactions SHALL be separated by exactly one IDLE cycle, and the slave port SHALL be occupied at most every other cycle when the slave responds in a single cycle.
REQ-022 A master that deasserts valid while granted (protocol violation) SHALL propagate valid=0 to the slave, and the block SHALL stay in BUSY until s_resp.ready=1.
REQ-023 A slave ready=1 while the block is IDLE SHALL be ignored, and no master SHALL see it.
REQ-024 A master that asserts valid in the cycle another master's transaction completes SHALL be considered in the following IDLE cycle under the updated rr_ptr.
REQ-025 Fairness: with all masters continuously requesting, each master SHALL be granted exactly once in every N_MASTERS consecutive grants.
REQ-026 grant and rr_ptr SHALL be $clog2(N_MASTERS) bits wide, and for non-power-of-2 N_MASTERS the wrap SHALL be explicit so the index never reaches N_MASTERS.

Reset
REQ-027 While rst_n=0, the block SHALL be in IDLE with grant=0, rr_ptr=0, s_req all zeros, and all m_resp slices zero, independent of clk.
REQ-028 On an asynchronous reset during BUSY, the block SHALL abandon the transaction and remove the slave request immediately; no ready SHALL reach any master.
REQ-029 On release of rst_n, the first arbitration SHALL start from master 0.

Verification
REQ-030 A bench SHALL cover these scenarios with N_MASTERS=3 and ADDR_W=16:
- Single request: m1 valid, addr=0x1234, wdata=0xDEADBEEF, wstrb=0xF; slave ready 2 cycles after the request appears -> s_req matches m1 from cycle 1, m1 ready=1 for exactly one cycle, m0 and m2 read zero throughout, rr_ptr=2 afterwards.
- Read data: m0 read (wstrb=0) with slave rdata=0xCAFEF00D and ready=1 -> m0 sees rdata=0xCAFEF00D and ready=1 in the same cycle; the other slices read zero.
- Contention: m0, m1 and m2 all hold valid, slave always ready -> grant order 0,1,2,0,1,2 with one IDLE cycle between grants.
- Wrap: rr_ptr=2, only m0 and m1 requesting -> m0 is granted first, then m1.
- Reset mid-transaction: rst_n=0 while BUSY on m2 -> s_req=0 and all m_resp=0 immediately; after release, with all masters requesting, m0 is granted first.
- Spurious and stall: slave ready=1 while IDLE -> no master ready; slave holds ready=0 for 20 cycles -> grant is stable and the other requesters wait.
